// File: rtl/hex_display_scanner.sv
// rtl/hex_display_scanner.sv - N-digit hex 7-segment driver with static and multiplexed outputs
module hex_display_scanner #(
    parameter int NUM_DIGITS   = 4,
    parameter int SCAN_DIV     = 25000,
    parameter int GUARD_CYCLES = 250,
    parameter bit ACTIVE_LOW   = 1'b1
) (
    input  logic                    clk25,
    input  logic                    rst_n,
    input  logic                    latch,
    input  logic [4*NUM_DIGITS-1:0] value,
    input  logic                    blank_lz,
    input  logic [NUM_DIGITS-1:0]   digit_en,
    output logic [7*NUM_DIGITS-1:0] seg_out,
    output logic [6:0]              mux_seg,
    output logic [NUM_DIGITS-1:0]   mux_sel,
    output logic                    scan_tick
);

    localparam int PW = $clog2(SCAN_DIV);
    localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

    // XOR masks that turn an active-high pattern into the output polarity
    localparam logic [6:0]            SEG_DARK = ACTIVE_LOW ? 7'h7F : 7'h00;
    localparam logic [NUM_DIGITS-1:0] SEL_OFF  = ACTIVE_LOW ? {NUM_DIGITS{1'b1}} : {NUM_DIGITS{1'b0}};

    logic [4*NUM_DIGITS-1:0] hold;
    logic [PW-1:0]           presc;
    logic [IW-1:0]           index;
    logic [PW-1:0]           presc_next;
    logic [IW-1:0]           index_next;
    logic [NUM_DIGITS-1:0]   upper_zero;
    logic [7*NUM_DIGITS-1:0] seg_next;
    logic                    guard_next;

    // Active-high glyph {g,f,e,d,c,b,a} for one nibble
    function automatic logic [6:0] glyph(input logic [3:0] nib);
        logic [6:0] g;
        case (nib)
            4'h0: g = 7'h3F;
            4'h1: g = 7'h06;
            4'h2: g = 7'h5B;
            4'h3: g = 7'h4F;
            4'h4: g = 7'h66;
            4'h5: g = 7'h6D;
            4'h6: g = 7'h7D;
            4'h7: g = 7'h07;
            4'h8: g = 7'h7F;
            4'h9: g = 7'h6F;
            4'hA: g = 7'h77;
            4'hB: g = 7'h7C;
            4'hC: g = 7'h39;
            4'hD: g = 7'h5E;
            4'hE: g = 7'h79;
            default: g = 7'h71;
        endcase
        return g;
    endfunction

    // Per-digit segment pattern from the hold register, with leading-zero and mask blanking
    always_comb begin
        logic run;
        run        = 1'b1;
        upper_zero = '0;
        seg_next   = '0;
        for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
            run           = run && (hold[4*i +: 4] == 4'd0);
            upper_zero[i] = run;
            if (!digit_en[i] || (blank_lz && (i > 0) && upper_zero[i]))
                seg_next[7*i +: 7] = SEG_DARK;
            else
                seg_next[7*i +: 7] = glyph(hold[4*i +: 4]) ^ SEG_DARK;
        end
    end

    // Next prescaler/index; mux registers are computed from these so they align with the live slot
    always_comb begin
        presc_next = presc + PW'(1);
        index_next = index;
        if (presc == PW'(SCAN_DIV - 1)) begin
            presc_next = '0;
            index_next = (index == IW'(NUM_DIGITS - 1)) ? '0 : index + IW'(1);
        end
        guard_next = int'(presc_next) < GUARD_CYCLES;
    end

    // Hold register, static segments, scan counters and multiplexed outputs
    always_ff @(posedge clk25 or negedge rst_n) begin
        if (!rst_n) begin
            hold      <= '0;
            presc     <= '0;
            index     <= '0;
            seg_out   <= {NUM_DIGITS{SEG_DARK}};
            mux_seg   <= SEG_DARK;
            mux_sel   <= SEL_OFF;
            scan_tick <= 1'b0;
        end else begin
            if (latch)
                hold <= value;
            seg_out   <= seg_next;
            presc     <= presc_next;
            index     <= index_next;
            scan_tick <= (presc_next == '0);
            if (guard_next) begin
                mux_seg <= SEG_DARK;
                mux_sel <= SEL_OFF;
            end else begin
                mux_seg <= seg_next[7*index_next +: 7];
                mux_sel <= (NUM_DIGITS'(1) << index_next) ^ SEL_OFF;
            end
        end
    end

endmodule

// File: tb/tb_hex_display_scanner.sv
// tb/tb_hex_display_scanner.sv - self-checking bench for hex_display_scanner
module tb_hex_display_scanner;

    localparam int N  = 4;
    localparam int D  = 10;
    localparam int G  = 2;

    logic          clk25 = 1'b0;
    logic          rst_n;
    logic          latch;
    logic [4*N-1:0] value;
    logic          blank_lz;
    logic [N-1:0]  digit_en;
    logic [7*N-1:0] seg_out;
    logic [6:0]    mux_seg;
    logic [N-1:0]  mux_sel;
    logic          scan_tick;

    int checks = 0;
    int fails  = 0;

    hex_display_scanner #(
        .NUM_DIGITS(N), .SCAN_DIV(D), .GUARD_CYCLES(G), .ACTIVE_LOW(1'b1)
    ) dut (
        .clk25(clk25), .rst_n(rst_n), .latch(latch), .value(value),
        .blank_lz(blank_lz), .digit_en(digit_en), .seg_out(seg_out),
        .mux_seg(mux_seg), .mux_sel(mux_sel), .scan_tick(scan_tick)
    );

    always #20 clk25 = ~clk25;

    // Active-high glyphs {g,f,e,d,c,b,a}, written from the hex digit shapes
    logic [6:0] glyph_tab [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                   7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

    function automatic logic [7*N-1:0] expect_seg(input logic [4*N-1:0] h, input logic [N-1:0] en,
                                                  input logic blz);
        logic [7*N-1:0] s;
        s = '0;
        for (int i = 0; i < N; i++) begin
            logic [15:0] upper;
            upper = 16'(h >> (4 * i));
            if (!en[i] || (blz && i > 0 && upper == 16'd0))
                s[7*i +: 7] = 7'h7F;
            else
                s[7*i +: 7] = ~glyph_tab[upper[3:0]];
        end
        return s;
    endfunction

    // Model: cycles since release, held value, and the segment image registered one cycle late
    int             k;
    logic [4*N-1:0] m_hold;
    logic [7*N-1:0] m_seg;
    always @(posedge clk25 or negedge rst_n) begin
        if (!rst_n) begin
            k      <= 0;
            m_hold <= '0;
            m_seg  <= '1;
        end else begin
            k     <= k + 1;
            m_seg <= expect_seg(m_hold, digit_en, blank_lz);
            if (latch) m_hold <= value;
        end
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Every low phase: all outputs against the model
    always @(negedge clk25) begin
        int p, idx;
        logic [6:0] e_mseg;
        logic [N-1:0] e_msel;
        p   = k % D;
        idx = (k / D) % N;
        if (p < G) begin
            e_mseg = 7'h7F;
            e_msel = '1;
        end else begin
            e_mseg = m_seg[7*idx +: 7];
            e_msel = ~(N'(1) << idx);
        end
        chk("seg_out", 64'(seg_out), 64'(m_seg));
        chk("mux_seg", 64'(mux_seg), 64'(e_mseg));
        chk("mux_sel", 64'(mux_sel), 64'(e_msel));
        chk("scan_tick", 64'(scan_tick), 64'(k > 0 && p == 0));
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge clk25);
    endtask

    task automatic latch_pulse(input logic [4*N-1:0] v);
        value = v;
        latch = 1'b1;
        cyc(1);
        latch = 1'b0;
    endtask

    initial begin
        bit found;
        rst_n = 1'b0; latch = 1'b0; value = '0; blank_lz = 1'b0; digit_en = '1;
        cyc(3);
        chk("rst_seg_out", 64'(seg_out), 64'({7*N{1'b1}}));
        chk("rst_mux_seg", 64'(mux_seg), 64'h7F);
        chk("rst_mux_sel", 64'(mux_sel), 64'hF);
        chk("rst_tick", 64'(scan_tick), 64'h0);
        rst_n = 1'b1;
        cyc(2);
        chk("zero_all", 64'(seg_out), 64'({7'h40, 7'h40, 7'h40, 7'h40}));

        value = 16'h1A3F; latch = 1'b1;
        cyc(1);
        latch = 1'b0;
        chk("latch_lat1", 64'(seg_out), 64'({7'h40, 7'h40, 7'h40, 7'h40}));
        cyc(1);
        chk("latch_1A3F", 64'(seg_out), 64'({7'h79, 7'h08, 7'h30, 7'h0E}));
        value = 16'h2222;
        cyc(3);
        chk("no_latch", 64'(seg_out), 64'({7'h79, 7'h08, 7'h30, 7'h0E}));

        blank_lz = 1'b1;
        latch_pulse(16'h0050);
        cyc(2);
        chk("lz_0050", 64'(seg_out), 64'({7'h7F, 7'h7F, 7'h12, 7'h40}));
        latch_pulse(16'h0000);
        cyc(2);
        chk("lz_0000", 64'(seg_out), 64'({7'h7F, 7'h7F, 7'h7F, 7'h40}));
        blank_lz = 1'b0;
        cyc(2);
        chk("nolz_0000", 64'(seg_out), 64'({7'h40, 7'h40, 7'h40, 7'h40}));

        digit_en = 4'b1011;
        latch_pulse(16'h1A3F);
        cyc(2);
        chk("mask_1011", 64'(seg_out), 64'({7'h79, 7'h7F, 7'h30, 7'h0E}));
        cyc(45);
        digit_en = '1;

        // Transparent latch with a moving value, mid-slot updates
        latch = 1'b1;
        for (int i = 0; i < 16; i++) begin
            value = 16'(16'h1111 * i) ^ 16'h0F30;
            cyc(1);
        end
        latch = 1'b0;
        blank_lz = 1'b1;
        latch_pulse(16'h00B0);
        cyc(12);

        // Asynchronous reset while digit 2 is being driven
        found = 1'b0;
        for (int i = 0; i < 60 && !found; i++) begin
            cyc(1);
            if (mux_sel == 4'b1011) found = 1'b1;
        end
        chk("wait_idx2", 64'(found), 64'h1);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_seg_out", 64'(seg_out), 64'({7*N{1'b1}}));
        chk("arst_mux_seg", 64'(mux_seg), 64'h7F);
        chk("arst_mux_sel", 64'(mux_sel), 64'hF);
        cyc(2);
        rst_n = 1'b1;
        cyc(3);
        chk("resume_idx0", 64'(mux_sel), 64'b1110);
        cyc(45);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
